// File: rtl/stage_mul_pipe.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) beside EX.
// Tracks in-flight destinations for decode hazard checks; supports stall and flush.
module stage_mul_pipe #(
    parameter int unsigned WD_SIZE  = 32,
    parameter int unsigned LATENCY  = 3,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned RD_SIZE  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [2:0]          funct3_i,
    input  logic [WD_SIZE-1:0]  op1_i,
    input  logic [WD_SIZE-1:0]  op2_i,
    input  logic [RD_SIZE-1:0]  rd_i,
    input  logic                flush_i,
    input  logic                stall_i,
    output logic                valid_o,
    output logic [WD_SIZE-1:0]  result_o,
    output logic [RD_SIZE-1:0]  rd_o,
    output logic                illegal_o,
    output logic [NUM_REGS-1:0] pending_rd_o,
    output logic                busy_o
);

    localparam int unsigned LAST = LATENCY - 1;
    localparam int unsigned PW   = 2 * WD_SIZE;

    logic [LATENCY-1:0] slot_valid;
    logic [WD_SIZE-1:0] slot_res [LATENCY];
    logic [RD_SIZE-1:0] slot_rd  [LATENCY];
    logic               illegal_q;

    logic               advance;
    logic               accept;
    logic               op1_signed;
    logic               op2_signed;
    logic [PW-1:0]      op1_ext;
    logic [PW-1:0]      op2_ext;
    logic [PW-1:0]      product;
    logic [WD_SIZE-1:0] sel_res;

    // Pipe moves unless the occupied output slot is being held by downstream.
    assign advance = !(slot_valid[LAST] && stall_i);
    assign ready_o = advance;
    assign accept  = valid_i && !funct3_i[2];

    // Full product is formed at entry; later slots only carry the selected half.
    always_comb begin
        op1_signed = (funct3_i[1:0] == 2'b01) || (funct3_i[1:0] == 2'b10);
        op2_signed = (funct3_i[1:0] == 2'b01);
        op1_ext    = {{WD_SIZE{op1_signed & op1_i[WD_SIZE-1]}}, op1_i};
        op2_ext    = {{WD_SIZE{op2_signed & op2_i[WD_SIZE-1]}}, op2_i};
        product    = op1_ext * op2_ext;
        sel_res    = (funct3_i[1:0] == 2'b00) ? product[WD_SIZE-1:0] : product[PW-1:WD_SIZE];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid <= '0;
            illegal_q  <= 1'b0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                slot_res[i] <= '0;
                slot_rd[i]  <= '0;
            end
        end else begin
            illegal_q <= valid_i && funct3_i[2];
            if (advance) begin
                slot_res[0] <= sel_res;
                slot_rd[0]  <= rd_i;
                for (int unsigned i = 1; i < LATENCY; i++) begin
                    slot_res[i] <= slot_res[i-1];
                    slot_rd[i]  <= slot_rd[i-1];
                end
            end
            // Flush wins over stall and also kills the op offered this cycle.
            if (flush_i) begin
                slot_valid <= '0;
            end else if (advance) begin
                slot_valid <= (slot_valid << 1) | LATENCY'(accept);
            end
        end
    end

    always_comb begin
        pending_rd_o = '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            if (slot_valid[i] && (slot_rd[i] != '0)) begin
                pending_rd_o[slot_rd[i]] = 1'b1;
            end
        end
    end

    assign busy_o    = |slot_valid;
    assign valid_o   = slot_valid[LAST];
    assign result_o  = slot_res[LAST];
    assign rd_o      = slot_rd[LAST];
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_stage_mul_pipe.sv
// Bench for stage_mul_pipe: three instances (LATENCY 3, 1, 8) driven in lockstep,
// each compared every cycle against a queue-based transaction model.
module tb_stage_mul_pipe;

    localparam int unsigned LAT0 = 3;
    localparam int unsigned LAT1 = 1;
    localparam int unsigned LAT2 = 8;

    typedef struct {
        bit          v;
        logic [31:0] res;
        logic [4:0]  rd;
    } slot_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        flush_i;
    logic        stall_i;

    logic [2:0]  ready_w;
    logic [2:0]  valid_w;
    logic [2:0]  ill_w;
    logic [2:0]  busy_w;
    logic [31:0] res_w  [3];
    logic [4:0]  rd_w   [3];
    logic [31:0] pend_w [3];

    int unsigned lat [3] = '{LAT0, LAT1, LAT2};
    slot_t       mq [3][$];
    bit          ill_exp [3];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    int          ops0    = 0;
    logic [31:0] hold_res;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? LAT0 : (g == 1) ? LAT1 : LAT2;
        stage_mul_pipe #(
            .WD_SIZE (32),
            .LATENCY (L),
            .NUM_REGS(32),
            .RD_SIZE (5)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .valid_i     (valid_i),
            .ready_o     (ready_w[g]),
            .funct3_i    (funct3),
            .op1_i       (op1),
            .op2_i       (op2),
            .rd_i        (rd),
            .flush_i     (flush_i),
            .stall_i     (stall_i),
            .valid_o     (valid_w[g]),
            .result_o    (res_w[g]),
            .rd_o        (rd_w[g]),
            .illegal_o   (ill_w[g]),
            .pending_rd_o(pend_w[g]),
            .busy_o      (busy_w[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic string tg(input string s, input int k);
        return $sformatf("%s_lat%0d", s, lat[k]);
    endfunction

    // Architectural definition of the four multiply flavours using 64-bit integers.
    function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f[1:0])
            2'b00:   begin p = ua * ub; return p[31:0];  end
            2'b01:   begin p = sa * sb; return p[63:32]; end
            2'b10:   begin p = sa * ub; return p[63:32]; end
            default: begin p = ua * ub; return p[63:32]; end
        endcase
    endfunction

    function automatic logic [31:0] exp_pending(input int k);
        logic [31:0] m = '0;
        for (int i = 0; i < mq[k].size(); i++)
            if (mq[k][i].v && mq[k][i].rd != 5'd0) m[mq[k][i].rd] = 1'b1;
        return m;
    endfunction

    function automatic logic exp_busy(input int k);
        logic b = 1'b0;
        for (int i = 0; i < mq[k].size(); i++) b = b | mq[k][i].v;
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            for (int unsigned i = 0; i < lat[k]; i++) mq[k].push_back('{v: 1'b0, res: 32'h0, rd: 5'h0});
            ill_exp[k] = 1'b0;
        end
    endtask

    // Queue front is the output; an accepted op needs LATENCY advancing edges to reach it.
    task automatic model_step();
        slot_t s;
        bit    adv;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            adv = !(mq[k][0].v && stall_i);
            ill_exp[k] = valid_i && funct3[2];
            if (flush_i) begin
                for (int i = 0; i < mq[k].size(); i++) mq[k][i].v = 1'b0;
            end else if (adv) begin
                s.v   = valid_i && !funct3[2];
                s.res = ref_mul(funct3, op1, op2);
                s.rd  = rd;
                void'(mq[k].pop_front());
                mq[k].push_back(s);
                if (k == 0 && s.v) ops0++;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk(tg("valid_o", k), 64'(valid_w[k]), 64'(mq[k][0].v));
            if (mq[k][0].v) begin
                chk(tg("result_o", k), 64'(res_w[k]), 64'(mq[k][0].res));
                chk(tg("rd_o", k), 64'(rd_w[k]), 64'(mq[k][0].rd));
            end
            chk(tg("illegal_o", k), 64'(ill_w[k]), 64'(ill_exp[k]));
            chk(tg("pending_rd_o", k), 64'(pend_w[k]), 64'(exp_pending(k)));
            chk(tg("busy_o", k), 64'(busy_w[k]), 64'(exp_busy(k)));
        end
    endtask

    // Inputs are set at the falling edge; ready is checked, the edge taken, outputs checked.
    task automatic tick();
        #1;
        for (int k = 0; k < 3; k++)
            chk(tg("ready_o", k), 64'(ready_w[k]), 64'(!(mq[k][0].v && stall_i)));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        valid_i = 1'b1;
        funct3  = f;
        op1     = a;
        op2     = b;
        rd      = r;
    endtask

    task automatic idle();
        valid_i = 1'b0;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int cycles;
        reset   = 1'b1;
        valid_i = 1'b0;
        funct3  = 3'b000;
        op1     = '0;
        op2     = '0;
        rd      = '0;
        flush_i = 1'b0;
        stall_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("reset_result0", 64'(res_w[0]), 64'h0);
        chk("reset_rd0", 64'(rd_w[0]), 64'h0);
        reset = 1'b0;

        // Single MUL: 7 * -3
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        tick();
        idle();
        chk("mul_pend_c1", 64'(pend_w[0][5]), 64'h1);
        tick();
        chk("mul_pend_c2", 64'(pend_w[0][5]), 64'h1);
        tick();
        chk("mul_valid_c3", 64'(valid_w[0]), 64'h1);
        chk("mul_result_c3", 64'(res_w[0]), 64'hFFFF_FFEB);
        chk("mul_rd_c3", 64'(rd_w[0]), 64'd5);
        chk("mul_pend_c3", 64'(pend_w[0][5]), 64'h1);
        tick();
        chk("mul_valid_c4", 64'(valid_w[0]), 64'h0);

        // Back-to-back high-half variants
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1);
        tick();
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        tick();
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        tick();
        idle();
        chk("mulh_result", 64'(res_w[0]), 64'h4000_0000);
        tick();
        chk("mulhsu_result", 64'(res_w[0]), 64'hFFFF_FFFF);
        tick();
        chk("mulhu_result", 64'(res_w[0]), 64'hFFFF_FFFE);
        tick();

        // Output stall for four cycles
        issue(3'b000, 32'd3, 32'd4, 5'd1);
        tick();
        issue(3'b000, 32'd5, 32'd6, 5'd2);
        tick();
        idle();
        tick();
        chk("stall_head_rd", 64'(rd_w[0]), 64'd1);
        hold_res = res_w[0];
        stall_i = 1'b1;
        repeat (4) begin
            #1;
            chk("stall_ready", 64'(ready_w[0]), 64'h0);
            tick();
            chk("stall_hold_res", 64'(res_w[0]), 64'(hold_res));
            chk("stall_hold_rd", 64'(rd_w[0]), 64'd1);
        end
        stall_i = 1'b0;
        tick();
        chk("stall_next_valid", 64'(valid_w[0]), 64'h1);
        chk("stall_next_rd", 64'(rd_w[0]), 64'd2);
        chk("stall_next_res", 64'(res_w[0]), 64'd30);
        tick();

        // Flush with three in flight plus one presented
        for (int i = 0; i < 3; i++) begin
            issue(3'b000, 32'(i + 2), 32'd9, 5'(i + 7));
            tick();
        end
        issue(3'b011, 32'd11, 32'd12, 5'd10);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        idle();
        chk("flush_busy", 64'(busy_w[0]), 64'h0);
        chk("flush_pending", 64'(pend_w[0]), 64'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("flush_no_valid", 64'(valid_w[0]), 64'h0);
        end
        issue(3'b000, 32'd13, 32'd3, 5'd4);
        tick();
        idle();
        repeat (2) tick();
        chk("post_flush_res", 64'(res_w[0]), 64'd39);
        tick();

        // Illegal funct3 followed by a legal op
        issue(3'b100, 32'd1, 32'd1, 5'd6);
        tick();
        chk("illegal_pulse", 64'(ill_w[0]), 64'h1);
        issue(3'b000, 32'd8, 32'd8, 5'd9);
        tick();
        idle();
        chk("illegal_clear", 64'(ill_w[0]), 64'h0);
        chk("illegal_no_valid", 64'(valid_w[0]), 64'h0);
        tick();
        tick();
        chk("after_illegal_rd", 64'(rd_w[0]), 64'd9);
        chk("after_illegal_res", 64'(res_w[0]), 64'd64);
        tick();

        // Asynchronous reset mid-stream
        issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12);
        tick();
        tick();
        tick();
        idle();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("async_rst_valid", 64'(valid_w[0]), 64'h0);
        chk("async_rst_busy", 64'(busy_w[0]), 64'h0);
        chk("async_rst_res", 64'(res_w[0]), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            tick();
            chk("post_rst_quiet", 64'(valid_w[0]), 64'h0);
        end

        // Randomised traffic
        cycles = 0;
        ops0   = 0;
        while (ops0 < 10000 && cycles < 60000) begin
            valid_i = ($urandom_range(0, 99) < 80);
            funct3  = {($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3))};
            op1     = pick_op();
            op2     = pick_op();
            rd      = 5'($urandom_range(0, 31));
            stall_i = ($urandom_range(0, 99) < 25);
            flush_i = ($urandom_range(0, 99) < 3);
            tick();
            cycles++;
        end
        chk("random_ops_done", 64'(ops0 >= 10000), 64'h1);
        valid_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stage_mul_pipe.md
Name: stage_mul_pipe

Overview:
- Parametrised, fully pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU).
- Sits beside stage_ex: EX issues multiply ops into it and it returns results toward MEM/WB.
- Generalises the current fixed single-cycle EX datapath: configurable operand width and pipeline depth, downstream back-pressure, branch flush, and in-flight destination tracking for decode hazard detection.

Parameters:
- WD_SIZE, 32, operand/result width in bits.
- LATENCY, 3, number of pipeline slots from accept to valid_o; legal range 1..8.
- NUM_REGS, 32, architectural register count; width of pending_rd_o.
- RD_SIZE, 5, register index width (clog2 of NUM_REGS).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_i  input  1  multiply op offered this cycle.
- ready_o  output  1  pipe can advance; op accepted when valid_i && ready_o.
- funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is illegal here.
- op1_i  input  WD_SIZE  rs1 data.
- op2_i  input  WD_SIZE  rs2 data.
- rd_i  input  RD_SIZE  destination register.
- flush_i  input  1  kill all in-flight ops (taken branch/jump).
- stall_i  input  1  downstream cannot take the output this cycle.
- valid_o  output  1  result slot valid.
- result_o  output  WD_SIZE  selected product half.
- rd_o  output  RD_SIZE  destination of the output slot.
- illegal_o  output  1  registered one-cycle pulse: valid_i with funct3_i[2]=1 was presented.
- pending_rd_o  output  NUM_REGS  bit r set iff some valid slot targets r, r!=0.
- busy_o  output  1  OR of all slot valids.

Behaviour:
- Reset values (async, immediate): all slot valids 0, valid_o 0, result_o 0, rd_o 0, illegal_o 0, pending_rd_o 0, busy_o 0. Reset mid-operation discards everything; no output after release until new ops are accepted.
- Slots S0..S(LATENCY-1). Each slot holds valid, funct3, rd and partial/full product. The last slot drives valid_o/result_o/rd_o.
- advance = !(valid_o && stall_i); ready_o = advance (combinational). ready_o does not depend on valid_i.
- When advance=1, every slot shifts forward one position; S0 loads (valid_i && !funct3_i[2]).
- When advance=0, all slots hold, including bubbles (no bubble compression).
- Latency: op accepted at edge t gives valid_o=1 after edge t+LATENCY-1, i.e. visible in cycle t+LATENCY, provided no stall. Throughput is 1 op/cycle.
- Stall with valid_o=1 holds result_o/rd_o stable until stall_i drops. The op leaves on the first edge where stall_i=0.
- Arithmetic:
  - Extend op1 to WD_SIZE+1 bits: signed for MULH/MULHSU, zero for MULHU/MUL. Extend op2 signed for MULH only.
  - Form the 2*WD_SIZE product.
  - MUL returns bits [WD_SIZE-1:0]; all others return bits [2*WD_SIZE-1:WD_SIZE].
  - The split of multiplier logic across slots is an implementation choice; results must be bit-exact.
- Illegal funct3 (1xx): op not inserted; illegal_o=1 on the next cycle only; the pipe otherwise advances normally.
- Flush: on an edge with flush_i=1, all slot valids clear, including the op presented that cycle. Flush has priority over stall. valid_o=0 the cycle after. illegal_o is still reported.
- rd=0: op computes and emits normally; it is excluded from pending_rd_o.
- pending_rd_o and busy_o are combinational from slot registers, not from inputs.
- LATENCY=1: single register stage; the advance rule still applies.

Test Plan:
- LATENCY=3, issue MUL op1=7, op2=0xFFFFFFFD, rd=5 at cycle 0 -> valid_o=1 in cycle 3, result_o=0xFFFFFFEB, rd_o=5; pending_rd_o[5]=1 during cycles 1-3.
- Back-to-back: MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. Results appear on consecutive cycles 3, 4, 5.
- Output stall: hold stall_i=1 for 4 cycles while valid_o=1 -> ready_o=0, result_o/rd_o constant. The next op exits exactly 1 cycle after stall_i drops; no loss or duplication.
- Flush with 3 ops in flight plus one presented -> next cycle busy_o=0, pending_rd_o=0, and no valid_o for 5 cycles. An op issued after the flush completes normally.
- valid_i with funct3=100 -> no valid_o ever, illegal_o=1 for exactly one cycle; a following legal op is unaffected. Assert reset mid-stream -> outputs 0 immediately.
- Randomised 10k ops with random stall/flush, WD_SIZE=32 and LATENCY in {1,3,8}, compared against a reference model -> zero mismatches, and ordering preserved.
